lfsr_alu_seq: RTL and testbench

- Parametrised, registered successor to the processor ALU.
- Single-cycle ops: CMP, XOR, ADD, SUB, shifts and parity. The result is registered, with a Start/Done handshake.
- Adds a multi-cycle LFSR engine that advances a WIDTH-bit Fibonacci LFSR a programmable number of steps from one Start.
- Sits in the execute stage. The controller stalls on Busy.

---
 rtl/lfsr_alu_seq.sv | 171 +++++++++++++++++
 tb/tb_lfsr_alu_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_alu_seq.sv
// lfsr_alu_seq: registered execute-stage ALU with a Start/Done handshake and a
// multi-cycle Fibonacci LFSR engine (Busy is high while an LFSR run is active).
// Optional feature macro: LFSR_PERIOD_EN adds the Period output and lets an
// LFSR run stop early when the state returns to its seed.
`timescale 1ns/1ps

module lfsr_alu_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [2:0]       Opcode,
   input  logic [WIDTH-1:0] InA,
   input  logic [WIDTH-1:0] InB,
   input  logic [CNT_W-1:0] Steps,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Out,
   output logic             GE_Flag,
`ifdef LFSR_PERIOD_EN
   output logic             Zero_Flag,
   output logic [CNT_W-1:0] Period
`else
   output logic             Zero_Flag
`endif
);

   localparam logic [2:0] OP_CMP  = 3'd0;
   localparam logic [2:0] OP_LFSR = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_SUB  = 3'd4;
   localparam logic [2:0] OP_LSHL = 3'd5;
   localparam logic [2:0] OP_LSHR = 3'd6;
   localparam logic [2:0] OP_PAR  = 3'd7;

   // Shift amounts at or beyond the datapath width flush the result to zero.
   localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] lfsr_state;
   logic [WIDTH-1:0] taps;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] lfsr_next;
   logic [WIDTH-1:0] alu_result;
   logic             run_finish;

`ifdef LFSR_PERIOD_EN
   logic [WIDTH-1:0] seed;
   logic [CNT_W-1:0] steps_latched;
   logic             run_match;
   logic [CNT_W-1:0] steps_taken;
`endif

   // One Fibonacci step: shift left and feed the parity of the tapped bits in at bit 0.
   always_comb begin
      lfsr_next = {lfsr_state[WIDTH-2:0], ^(taps & lfsr_state)};
   end

   // Decide whether the current RUN edge is the last one of the run.
`ifdef LFSR_PERIOD_EN
   always_comb begin
      run_match   = (lfsr_next == seed);
      steps_taken = steps_latched - cnt + CNT_W'(1);
      run_finish  = run_match || (cnt == CNT_W'(1));
   end
`else
   always_comb begin
      run_finish = (cnt == CNT_W'(1));
   end
`endif

   // Combinational result of the single-cycle operations, registered on acceptance.
   always_comb begin
      alu_result = '0;
      case (Opcode)
         OP_XOR:  alu_result = InA ^ InB;
         OP_ADD:  alu_result = InA + InB;
         OP_SUB:  alu_result = InA - InB;
         OP_LSHL: alu_result = (InB >= SHIFT_LIMIT) ? '0 : (InA << InB);
         OP_LSHR: alu_result = (InB >= SHIFT_LIMIT) ? '0 : (InA >> InB);
         OP_PAR:  alu_result = {{(WIDTH-1){1'b0}}, ^InB};
         default: alu_result = '0;
      endcase
   end

   // Control FSM and all registered outputs; Done is a one-cycle pulse on every completion.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         lfsr_state <= '0;
         taps       <= '0;
         cnt        <= '0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         Out        <= '0;
         GE_Flag    <= 1'b0;
         Zero_Flag  <= 1'b0;
`ifdef LFSR_PERIOD_EN
         seed          <= '0;
         steps_latched <= '0;
         Period        <= '0;
`endif
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  case (Opcode)
                     OP_CMP: begin
                        GE_Flag <= (InA >= InB);
                        Done    <= 1'b1;
                     end
                     OP_LFSR: begin
                        if (Steps == '0) begin
                           Out       <= InB;
                           Zero_Flag <= (InB == '0);
                           Done      <= 1'b1;
`ifdef LFSR_PERIOD_EN
                           Period    <= '0;
`endif
                        end else begin
                           lfsr_state <= InB;
                           taps       <= InA;
                           cnt        <= Steps;
                           Busy       <= 1'b1;
                           state      <= RUN;
`ifdef LFSR_PERIOD_EN
                           seed          <= InB;
                           steps_latched <= Steps;
`endif
                        end
                     end
                     default: begin
                        Out       <= alu_result;
                        Zero_Flag <= (alu_result == '0);
                        Done      <= 1'b1;
                     end
                  endcase
               end
            end
            RUN: begin
               lfsr_state <= lfsr_next;
               cnt        <= cnt - CNT_W'(1);
               if (run_finish) begin
                  Out       <= lfsr_next;
                  Zero_Flag <= (lfsr_next == '0);
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
                  state     <= IDLE;
`ifdef LFSR_PERIOD_EN
                  Period    <= run_match ? steps_taken : '0;
`endif
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_alu_seq.sv
// tb_lfsr_alu_seq: self-checking bench for lfsr_alu_seq. Directed cases plus
// randomized transactions, all compared against a behavioural model kept here.
// Follows the LFSR_PERIOD_EN macro the same way the design does.
`timescale 1ns/1ps

module tb_lfsr_alu_seq;

   localparam int WIDTH = 8;
   localparam int CNT_W = 8;

   logic             Clk     = 1'b0;
   logic             Reset_n = 1'b0;
   logic             Start   = 1'b0;
   logic [2:0]       Opcode  = 3'd0;
   logic [WIDTH-1:0] InA     = '0;
   logic [WIDTH-1:0] InB     = '0;
   logic [CNT_W-1:0] Steps   = '0;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Out;
   logic             GE_Flag;
   logic             Zero_Flag;
`ifdef LFSR_PERIOD_EN
   logic [CNT_W-1:0] Period;
   int               model_period = 0;
`endif

   int total = 0;
   int bad   = 0;

   int model_out  = 0;
   int model_ge   = 0;
   int model_zero = 0;

   lfsr_alu_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Start     (Start),
      .Opcode    (Opcode),
      .InA       (InA),
      .InB       (InB),
      .Steps     (Steps),
      .Busy      (Busy),
      .Done      (Done),
      .Out       (Out),
      .GE_Flag   (GE_Flag),
`ifdef LFSR_PERIOD_EN
      .Zero_Flag (Zero_Flag),
      .Period    (Period)
`else
      .Zero_Flag (Zero_Flag)
`endif
   );

   always #5 Clk = ~Clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference LFSR: walk the sequence arithmetically; optionally stop when the seed recurs.
   function automatic int lfsrRun(input int taps, input int seed, input int n, output int taken);
      int s;
      s     = seed;
      taken = 0;
      for (int i = 1; i <= n; i++) begin
         s = ((s * 2) % 256) + ($countones(taps & s) % 2);
`ifdef LFSR_PERIOD_EN
         if (s == seed) begin
            taken = i;
            return s;
         end
`endif
      end
      return s;
   endfunction

   task automatic modelReset();
      model_out  = 0;
      model_ge   = 0;
      model_zero = 0;
`ifdef LFSR_PERIOD_EN
      model_period = 0;
`endif
   endtask

   task automatic checkAllOutputs(input string tag);
      checkOutput({tag, "_out"},  Out,       model_out);
      checkOutput({tag, "_ge"},   GE_Flag,   model_ge);
      checkOutput({tag, "_zero"}, Zero_Flag, model_zero);
`ifdef LFSR_PERIOD_EN
      checkOutput({tag, "_period"}, Period, model_period);
`endif
   endtask

   // Issue one transaction, optionally poke Start mid-run, then check latency and results.
   task automatic applyStimulus(input logic [2:0] op, input int a, input int b, input int n, input bit poke);
      int exp_wait;
      int waited;
      int res;
      int taken;
      exp_wait = 0;
      case (op)
         3'd0: model_ge = (a >= b) ? 1 : 0;
         3'd1: begin
            if (n == 0) begin
               res = b;
               taken = 0;
            end else begin
               res = lfsrRun(a, b, n, taken);
               exp_wait = (taken != 0) ? taken : n;
            end
            model_out  = res;
            model_zero = (res == 0) ? 1 : 0;
`ifdef LFSR_PERIOD_EN
            model_period = taken;
`endif
         end
         default: begin
            case (op)
               3'd2:    res = a ^ b;
               3'd3:    res = (a + b) % 256;
               3'd4:    res = (a - b + 256) % 256;
               3'd5:    res = (b >= WIDTH) ? 0 : ((a << b) % 256);
               3'd6:    res = (b >= WIDTH) ? 0 : (a >> b);
               default: res = $countones(b) % 2;
            endcase
            model_out  = res;
            model_zero = (res == 0) ? 1 : 0;
         end
      endcase

      @(negedge Clk);
      Opcode = op;
      InA    = WIDTH'(a);
      InB    = WIDTH'(b);
      Steps  = CNT_W'(n);
      Start  = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      InA   = WIDTH'($urandom);
      InB   = WIDTH'($urandom);
      Steps = CNT_W'($urandom);
      waited = 0;
      while (!Done && waited < exp_wait + 4) begin
         checkOutput("busy_during", Busy, (exp_wait > 0) ? 1 : 0);
         if (poke && exp_wait >= 3 && waited == 2) begin
            Opcode = 3'($urandom_range(0, 7));
            Start  = 1'b1;
         end else begin
            Start = 1'b0;
         end
         @(negedge Clk);
         waited++;
      end
      Start = 1'b0;
      checkOutput("latency", waited, exp_wait);
      checkOutput("done", Done, 1);
      checkOutput("busy_at_done", Busy, 0);
      checkAllOutputs("result");
      @(negedge Clk);
      checkOutput("done_pulse", Done, 0);
   endtask

   // Assert reset asynchronously mid-cycle and check outputs clear before the next edge.
   task automatic resetMidCycle();
      @(posedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_busy", Busy, 0);
      checkOutput("rst_done", Done, 0);
      checkAllOutputs("rst");
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   initial begin
      int op;
      int a;
      int b;
      int n;
      bit saw_done;

      // Power-on reset
      repeat (3) @(negedge Clk);
      checkOutput("por_busy", Busy, 0);
      checkOutput("por_done", Done, 0);
      checkAllOutputs("por");
      Reset_n = 1'b1;

      // Make outputs non-zero, then reset mid-cycle
      applyStimulus(3'd2, 8'hF0, 8'h0F, 0, 1'b0);
      applyStimulus(3'd0, 8'h07, 8'h05, 0, 1'b0);
      resetMidCycle();
      applyStimulus(3'd3, 8'hFF, 8'h01, 0, 1'b0);
      checkOutput("add_wrap_const", Out, 8'h00);
      checkOutput("add_wrap_zero", Zero_Flag, 1);

      // Compare and subtract
      applyStimulus(3'd0, 8'h05, 8'h07, 0, 1'b0);
      checkOutput("cmp_lt_const", GE_Flag, 0);
      applyStimulus(3'd0, 8'h07, 8'h07, 0, 1'b0);
      checkOutput("cmp_eq_const", GE_Flag, 1);
      applyStimulus(3'd4, 8'h05, 8'h07, 0, 1'b0);
      checkOutput("sub_const", Out, 8'hFE);

      // LFSR runs
      applyStimulus(3'd1, 8'h01, 8'h01, 2, 1'b0);
      checkOutput("lfsr_a_const", Out, 8'h07);
      applyStimulus(3'd1, 8'hB8, 8'h01, 3, 1'b0);
      checkOutput("lfsr_b_const", Out, 8'h08);
      applyStimulus(3'd1, 8'hB8, 8'h5A, 0, 1'b0);
      checkOutput("lfsr_zero_steps_const", Out, 8'h5A);
      applyStimulus(3'd1, 8'h8E, 8'h33, 10, 1'b1);
      applyStimulus(3'd1, 8'hB8, 8'h00, 5, 1'b0);

      // Shifts and parity
      applyStimulus(3'd5, 8'h81, 1, 0, 1'b0);
      checkOutput("lshl_const", Out, 8'h02);
      applyStimulus(3'd5, 8'h81, 8, 0, 1'b0);
      checkOutput("lshl_flush_const", Out, 8'h00);
      applyStimulus(3'd6, 8'h81, 7, 0, 1'b0);
      checkOutput("lshr_const", Out, 8'h01);
      applyStimulus(3'd7, 8'h00, 8'h07, 0, 1'b0);
      checkOutput("par_const", Out, 8'h01);

      // Period detection case
      applyStimulus(3'd1, 8'h80, 8'h01, 20, 1'b1);
`ifdef LFSR_PERIOD_EN
      checkOutput("period_out_const", Out, 8'h01);
      checkOutput("period_const", Period, 8);
`else
      checkOutput("full_run_out_const", Out, 8'h10);
`endif

      // Reset in the middle of a run: no Done, back to idle
      @(negedge Clk);
      Opcode = 3'd1;
      InA    = 8'h80;
      InB    = 8'h01;
      Steps  = 8'd20;
      Start  = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (4) @(negedge Clk);
      checkOutput("pre_abort_busy", Busy, 1);
      Reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput("abort_busy", Busy, 0);
      checkOutput("abort_done", Done, 0);
      checkAllOutputs("abort");
      @(negedge Clk);
      Reset_n  = 1'b1;
      saw_done = 1'b0;
      repeat (25) begin
         @(negedge Clk);
         if (Done || Busy) saw_done = 1'b1;
      end
      checkOutput("abort_no_done", saw_done, 0);

      // Randomized transactions
      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 7);
         a  = $urandom_range(0, 255);
         b  = ((op == 5) || (op == 6)) ? $urandom_range(0, 10) : $urandom_range(0, 255);
         n  = (op == 1) ? $urandom_range(0, 24) : $urandom_range(0, 255);
         applyStimulus(3'(op), a, b, n, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
